ifb_fetch_unit: RTL and testbench
=================================

Name: ifb_fetch_unit

Overview:
- Instruction-fetch front end placed directly upstream of the datapath's decode/execute stage.
- Generates fetch PCs and issues word reads to the synchronous 4 KiB instruction memory.
- Buffers returned instructions with their PCs in a small FIFO and presents them downstream over a valid/ready handshake.
- Supports a branch/jump redirect that squashes all buffered and in-flight fetches.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h0000_3000: first fetch address after reset.
- ADDR_W, 10: instruction-memory word-address width; the memory is indexed by PC[ADDR_W+1:2].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  read strobe to instruction memory.
- imem_addr  out  ADDR_W  word address, equal to fetch_pc[ADDR_W+1:2].
- imem_rdata  in  32  read data, valid exactly one cycle after imem_req.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream accepts the head entry.
- out_ins  out  32  instruction at the FIFO head.
- out_pc  out  32  PC of out_ins.
- redirect  in  1  branch/jump taken; flush and restart.
- redirect_pc  in  32  restart address; bits [1:0] are forced to 0.
- perf_fetch, perf_flush, perf_stall  out  32 each  counters (see Optional Feature).

Behaviour:
- Reset values while rst=1:
  - fetch_pc=RESET_PC, so imem_addr=RESET_PC[ADDR_W+1:2].
  - imem_req=0, out_valid=0, out_ins=0, out_pc=0.
  - FIFO empty, in-flight flag cleared, counters 0.
  - Reset asserted mid-operation discards everything in the same way.
- FSM states:
  - RUN: normal operation.
  - SQUASH: one cycle following reset or redirect; imem_req=0 in this state.
  - RST -> SQUASH on rst deassert; SQUASH -> RUN unconditionally.
  - RUN -> SQUASH on redirect; redirect during SQUASH restarts SQUASH with the new target.
- Issue rule (RUN only): imem_req=1 when occupancy + inflight < DEPTH and redirect=0.
  - On issue: the request PC is captured into req_pc_q, req_v_q is set, and fetch_pc += 4.
- Response: in the cycle after issue, if req_v_q=1 and no redirect occurs, {req_pc_q, imem_rdata} is pushed into the FIFO.
- Pop: occurs when out_valid & out_ready. out_valid = FIFO non-empty. out_ins/out_pc are driven combinationally from the FIFO head.
- Overflow: cannot occur, because the issue credit includes the in-flight request.
- Underflow: impossible; a pop requires out_valid.
- Throughput: 1 instruction/cycle sustained with out_ready=1.
- Latency:
  - First cycle with rst=0: SQUASH.
  - Next cycle: first request issued.
  - out_valid rises 2 cycles after the first request.
- Redirect in cycle N:
  - FIFO cleared and req_v_q cleared at the N edge; the response returning in N+1 is dropped.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - Target requested in N+2; target visible at out_valid in N+4.
- Redirect with a same-cycle handshake: the pop is honoured (downstream consumed it), then the flush applies.
- Redirect with a same-cycle push: the push is dropped.
- Wrap-around:
  - fetch_pc wraps modulo 2^32.
  - imem_addr naturally wraps at 4 KiB.
  - FIFO pointers wrap modulo DEPTH using one extra bit for full/empty.
- Backpressure: with out_ready=0 and the FIFO full, imem_req stays 0 and fetch_pc holds.

Optional Feature:
- Macro: IFB_PERF_EN.
- When defined:
  - perf_fetch increments on each pushed (non-squashed) instruction.
  - perf_flush increments on each redirect.
  - perf_stall increments each cycle with out_valid & ~out_ready.
  - All three are 32-bit, wrapping, and reset to 0.
- When undefined: the three ports are tied to 0 and no counter flops are inferred.

Decomposition:
- Package ifb_pkg contains:
  - the RESET_PC default;
  - the ADDR_W default;
  - typedef ifb_entry_t {pc[31:0], ins[31:0]};
  - FSM state enum {ST_RST, ST_SQUASH, ST_RUN}.
- Sub-module ifb_fifo: synchronous FIFO of ifb_entry_t with push, pop, flush, full, empty, and count.
  - flush has priority over push; pop and flush in the same cycle is legal.

Test Plan:
- Reset release, out_ready=1, memory returns word = address: imem_addr=0x000 on the first request; out_pc sequence 0x3000, 0x3004, 0x3008… with one instruction per cycle after fill; ins matches memory.
- Hold out_ready=0 for 10 cycles: exactly DEPTH=4 entries buffered; imem_req=0 once full; no entry lost or duplicated after out_ready=1.
- redirect=1, redirect_pc=0x3043 mid-stream: next out_pc=0x3040 on the 4th cycle after redirect; the in-flight response is never output.
- redirect in the same cycle as an out handshake and a push: the handshaken entry counts as consumed; the pushed entry is dropped; FIFO empty next cycle.
- Assert rst for 1 cycle while the FIFO is full: all outputs return to reset values; fetch restarts at 0x3000.
- With IFB_PERF_EN defined: run 20 fetches, 2 redirects, and 5 stall cycles; the counters match exactly. Without the macro, all three counters read 0.

Source files
------------

// File: rtl/ifb_pkg.sv
// ifb_pkg: shared types and defaults for the instruction-fetch front end.
//   RESET_PC_DEF - default first fetch address after reset
//   ADDR_W_DEF   - default instruction-memory word-address width
//   ifb_entry_t  - buffered {pc, ins} pair
//   state_t      - fetch FSM states
package ifb_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam int ADDR_W_DEF = 10;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ifb_entry_t;
  typedef enum logic [1:0] {ST_RST, ST_SQUASH, ST_RUN} state_t;
endpackage

// File: rtl/ifb_if.sv
// ifb_if: instruction-memory bus, downstream valid/ready stream and redirect.
//   master - fetch unit side (drives imem_req/imem_addr and the out stream)
//   slave  - memory / decode / branch-unit side
interface ifb_if #(parameter int ADDR_W = 10);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_ins;
  logic [31:0]       out_pc;
  logic              redirect;
  logic [31:0]       redirect_pc;
  modport master(output imem_req, imem_addr, out_valid, out_ins, out_pc,
                 input imem_rdata, out_ready, redirect, redirect_pc);
  modport slave(input imem_req, imem_addr, out_valid, out_ins, out_pc,
                output imem_rdata, out_ready, redirect, redirect_pc);
endinterface

// File: rtl/ifb_fifo.sv
// ifb_fifo: synchronous FIFO of ifb_entry_t with flush.
//   clk, rst         - clock, synchronous active-high reset
//   flush            - empties the FIFO; wins over push, may coincide with pop
//   push, din        - write an entry
//   pop, dout        - read the head entry (dout is the head, combinational)
//   full, empty, count - occupancy status
module ifb_fifo import ifb_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  ifb_entry_t             din,
  output ifb_entry_t             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  ifb_entry_t mem [DEPTH];
  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [AW:0] wr, rd;
  assign count = wr - rd;
  assign empty = wr == rd;
  assign full  = count == (AW+1)'(DEPTH);
  assign dout  = mem[rd[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push) wr <= wr + (AW+1)'(1);
      if (pop)  rd <= rd + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/ifb_fetch_unit.sv
// ifb_fetch_unit: fetch PC generation, imem reads, instruction buffering, redirect.
//   clk, rst   - clock, synchronous active-high reset
//   bus        - ifb_if.master: imem_req/imem_addr/imem_rdata, out_valid/out_ready/
//                out_ins/out_pc, redirect/redirect_pc
//   perf_fetch, perf_flush, perf_stall - counters, live only with IFB_PERF_EN defined
module ifb_fetch_unit import ifb_pkg::*; #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          ADDR_W   = ADDR_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  ifb_if.master       bus,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_flush,
  output logic [31:0] perf_stall
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t          state;
  logic [31:0]     fetch_pc, req_pc_q;
  logic            req_v_q, issue, push, pop, full, empty;
  logic [CW-1:0]   count;
  ifb_entry_t      head, din;
  // Credit counts the in-flight request, so a returning word always has room.
  assign issue = !rst && state == ST_RUN && !bus.redirect && !full &&
                 (int'(count) + int'(req_v_q) < DEPTH);
  assign push = !rst && req_v_q && !bus.redirect;
  assign pop  = bus.out_valid && bus.out_ready;
  assign din  = '{pc: req_pc_q, ins: bus.imem_rdata};
  assign bus.imem_req  = issue;
  assign bus.imem_addr = rst ? RESET_PC[ADDR_W+1:2] : fetch_pc[ADDR_W+1:2];
  assign bus.out_valid = !rst && !empty;
  assign bus.out_ins   = bus.out_valid ? head.ins : '0;
  assign bus.out_pc    = bus.out_valid ? head.pc : '0;
  ifb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .flush(bus.redirect), .push(push), .pop(pop),
    .din(din), .dout(head), .full(full), .empty(empty), .count(count)
  );
  // Reset lands directly in SQUASH so the first post-reset cycle is the squash cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_SQUASH;
      fetch_pc <= RESET_PC;
      req_pc_q <= '0;
      req_v_q  <= 1'b0;
    end else begin
      state    <= (bus.redirect || state == ST_RST) ? ST_SQUASH : ST_RUN;
      req_v_q  <= issue;
      req_pc_q <= issue ? fetch_pc : req_pc_q;
      fetch_pc <= bus.redirect ? (bus.redirect_pc & ~32'd3) :
                  issue        ? fetch_pc + 32'd4 : fetch_pc;
    end
  end
`ifdef IFB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch <= '0;
      perf_flush <= '0;
      perf_stall <= '0;
    end else begin
      perf_fetch <= perf_fetch + 32'(push);
      perf_flush <= perf_flush + 32'(bus.redirect);
      perf_stall <= perf_stall + 32'(bus.out_valid && !bus.out_ready);
    end
  end
`else
  assign perf_fetch = '0;
  assign perf_flush = '0;
  assign perf_stall = '0;
`endif
endmodule

// File: tb/tb_ifb_fetch_unit.sv
// tb_ifb_fetch_unit: directed table-driven bench for ifb_fetch_unit.
module tb_ifb_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] perf_fetch, perf_flush, perf_stall;
  int tests = 0;
  int fails = 0;
  ifb_if #(.ADDR_W(10)) bus();
  ifb_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_3000), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .perf_fetch(perf_fetch), .perf_flush(perf_flush), .perf_stall(perf_stall)
  );
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [9:0] a);
    return 32'hC0DE_0000 | {22'b0, a};
  endfunction

  always @(posedge clk)
    if (bus.imem_req) bus.imem_rdata <= word(bus.imem_addr);

  typedef struct {
    logic        r, rdy, redir;
    logic [31:0] rpc;
    logic        req;
    logic [9:0]  addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t mk(input logic r, rdy, redir, input logic [31:0] rpc,
                              input logic req, input logic [9:0] addr,
                              input logic valid, input logic [31:0] pc);
    return '{r, rdy, redir, rpc, req, addr, valid, pc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, rdy, redir, input logic [31:0] rpc);
    rst = r;
    bus.out_ready = rdy;
    bus.redirect = redir;
    bus.redirect_pc = rpc;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t tv[36];

  initial begin
    bus.imem_rdata = '0;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tv[0]  = mk(1, 1, 0, 0, 0, 10'h000, 0, 0);
    tv[1]  = mk(0, 1, 0, 0, 0, 10'h000, 0, 0);
    tv[2]  = mk(0, 1, 0, 0, 1, 10'h000, 0, 0);
    tv[3]  = mk(0, 1, 0, 0, 1, 10'h001, 0, 0);
    tv[4]  = mk(0, 1, 0, 0, 1, 10'h002, 1, 32'h3000);
    tv[5]  = mk(0, 1, 0, 0, 1, 10'h003, 1, 32'h3004);
    tv[6]  = mk(0, 1, 0, 0, 1, 10'h004, 1, 32'h3008);
    tv[7]  = mk(0, 0, 0, 0, 1, 10'h005, 1, 32'h300C);
    tv[8]  = mk(0, 0, 0, 0, 1, 10'h006, 1, 32'h300C);
    for (int i = 9; i <= 16; i++) tv[i] = mk(0, 0, 0, 0, 0, 10'h007, 1, 32'h300C);
    tv[17] = mk(0, 1, 0, 0, 0, 10'h007, 1, 32'h300C);
    tv[18] = mk(0, 1, 0, 0, 1, 10'h007, 1, 32'h3010);
    tv[19] = mk(0, 1, 0, 0, 1, 10'h008, 1, 32'h3014);
    tv[20] = mk(0, 1, 0, 0, 1, 10'h009, 1, 32'h3018);
    tv[21] = mk(0, 1, 0, 0, 1, 10'h00A, 1, 32'h301C);
    tv[22] = mk(0, 1, 0, 0, 1, 10'h00B, 1, 32'h3020);
    tv[23] = mk(0, 1, 1, 32'h3043, 0, 10'h00C, 1, 32'h3024);
    tv[24] = mk(0, 1, 0, 0, 0, 10'h010, 0, 0);
    tv[25] = mk(0, 1, 0, 0, 1, 10'h010, 0, 0);
    tv[26] = mk(0, 1, 0, 0, 1, 10'h011, 0, 0);
    tv[27] = mk(0, 1, 0, 0, 1, 10'h012, 1, 32'h3040);
    tv[28] = mk(0, 1, 0, 0, 1, 10'h013, 1, 32'h3044);
    tv[29] = mk(0, 1, 1, 32'h3FFD, 0, 10'h014, 1, 32'h3048);
    tv[30] = mk(0, 1, 1, 32'hFFFF_FFFE, 0, 10'h3FF, 0, 0);
    tv[31] = mk(0, 1, 0, 0, 0, 10'h3FF, 0, 0);
    tv[32] = mk(0, 1, 0, 0, 1, 10'h3FF, 0, 0);
    tv[33] = mk(0, 1, 0, 0, 1, 10'h000, 0, 0);
    tv[34] = mk(0, 1, 0, 0, 1, 10'h001, 1, 32'hFFFF_FFFC);
    tv[35] = mk(0, 1, 0, 0, 1, 10'h002, 1, 32'h0000_0000);
    next_cycle();
    for (int i = 0; i < 36; i++) begin
      drive(tv[i].r, tv[i].rdy, tv[i].redir, tv[i].rpc);
      #5;
      chk($sformatf("v%0d req", i), 32'(bus.imem_req), 32'(tv[i].req));
      chk($sformatf("v%0d addr", i), 32'(bus.imem_addr), 32'(tv[i].addr));
      chk($sformatf("v%0d valid", i), 32'(bus.out_valid), 32'(tv[i].valid));
      chk($sformatf("v%0d pc", i), bus.out_pc, tv[i].pc);
      chk($sformatf("v%0d ins", i), bus.out_ins, tv[i].valid ? word(tv[i].pc[11:2]) : 32'h0);
      next_cycle();
    end
    // Fill the FIFO under backpressure, then reset for one cycle.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      next_cycle();
    end
    #5;
    chk("full valid", 32'(bus.out_valid), 32'h1);
    chk("full req", 32'(bus.imem_req), 32'h0);
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    #5;
    chk("rst req", 32'(bus.imem_req), 32'h0);
    chk("rst valid", 32'(bus.out_valid), 32'h0);
    chk("rst ins", bus.out_ins, 32'h0);
    chk("rst pc", bus.out_pc, 32'h0);
    chk("rst addr", 32'(bus.imem_addr), 32'h0);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    #5;
    chk("post-rst squash req", 32'(bus.imem_req), 32'h0);
    chk("post-rst squash valid", 32'(bus.out_valid), 32'h0);
    next_cycle();
    #5;
    chk("post-rst req", 32'(bus.imem_req), 32'h1);
    chk("post-rst addr", 32'(bus.imem_addr), 32'h0);
    next_cycle();
    next_cycle();
    #5;
    chk("post-rst valid", 32'(bus.out_valid), 32'h1);
    chk("post-rst pc", bus.out_pc, 32'h3000);
    chk("post-rst ins", bus.out_ins, word(10'h000));
    next_cycle();
    // Counter scenario: 20 pushes, 5 stall cycles, 2 redirects.
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    next_cycle();
    for (int c = 1; c <= 28; c++) begin
      drive(1'b0, !(c >= 18 && c <= 22), (c == 27 || c == 28), 32'h3100);
      if (c == 1) begin
        #5;
        chk("perf_fetch after rst", perf_fetch, 32'h0);
        chk("perf_flush after rst", perf_flush, 32'h0);
        chk("perf_stall after rst", perf_stall, 32'h0);
      end
      next_cycle();
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    #5;
`ifdef IFB_PERF_EN
    chk("perf_fetch", perf_fetch, 32'd20);
    chk("perf_flush", perf_flush, 32'd2);
    chk("perf_stall", perf_stall, 32'd5);
`else
    chk("perf_fetch", perf_fetch, 32'd0);
    chk("perf_flush", perf_flush, 32'd0);
    chk("perf_stall", perf_stall, 32'd0);
`endif
    chk("perf end valid", 32'(bus.out_valid), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
